// File: rtl/io_uart_bridge.sv
// CPU byte-I/O responder: uart_rx bytes queue in an RX FIFO for the CPU IN port,
// CPU OUT bytes queue in a TX FIFO for uart_tx. Sticky/live status on io_err.
module io_uart_bridge #(
    parameter int RX_AW = 4,
    parameter int TX_AW = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] io_in_data,
    output logic       io_in_vld,
    input  logic       io_in_rdy,
    input  logic [7:0] io_out_data,
    input  logic       io_out_vld,
    output logic       io_out_rdy,
    output logic [4:0] io_err,
    input  logic       err_clr,
    input  logic [7:0] rx_data,
    input  logic       rx_vld,
    input  logic       rx_ferr,
    output logic [7:0] tx_data,
    output logic       tx_vld,
    input  logic       tx_rdy
);
    localparam int RX_DEPTH = 1 << RX_AW;
    localparam int TX_DEPTH = 1 << TX_AW;

    // ---------------------------------------------------------------- RX FIFO
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RX_AW:0] rx_wr_ptr, rx_rd_ptr, rx_wr_nxt, rx_rd_nxt;
    logic           rx_empty_q, rx_full_q, rx_empty_nxt, rx_full_nxt;
    logic           rx_push, rx_pop, rx_push_ok, rx_ovf, rx_ferr_evt;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        rx_push      = rx_vld & ~rx_ferr;
        rx_pop       = io_in_vld & io_in_rdy;
        rx_push_ok   = rx_push & (~rx_full_q | rx_pop);
        rx_ovf       = rx_push & rx_full_q & ~rx_pop;
        rx_ferr_evt  = rx_vld & rx_ferr;
        rx_wr_nxt    = rx_wr_ptr + (RX_AW + 1)'(rx_push_ok);
        rx_rd_nxt    = rx_rd_ptr + (RX_AW + 1)'(rx_pop);
        rx_empty_nxt = (rx_wr_nxt == rx_rd_nxt);
        rx_full_nxt  = (rx_wr_nxt[RX_AW] != rx_rd_nxt[RX_AW]) &&
                       (rx_wr_nxt[RX_AW-1:0] == rx_rd_nxt[RX_AW-1:0]);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr  <= '0;
            rx_rd_ptr  <= '0;
            rx_empty_q <= 1'b1;
            rx_full_q  <= 1'b0;
        end else begin
            rx_wr_ptr  <= rx_wr_nxt;
            rx_rd_ptr  <= rx_rd_nxt;
            rx_empty_q <= rx_empty_nxt;
            rx_full_q  <= rx_full_nxt;
        end
    end

    // NOTE: storage arrays carry no reset; pointers alone define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (rx_push_ok)
            rx_mem[rx_wr_ptr[RX_AW-1:0]] <= rx_data;
    end

    assign io_in_vld  = ~rx_empty_q;
    assign io_in_data = io_in_vld ? rx_mem[rx_rd_ptr[RX_AW-1:0]] : 8'h00;

    // ---------------------------------------------------------------- TX FIFO
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TX_AW:0] tx_wr_ptr, tx_rd_ptr, tx_wr_nxt, tx_rd_nxt;
    logic           tx_empty_q, tx_full_q, tx_empty_nxt, tx_full_nxt;
    logic           tx_push, tx_pop;

    always_comb begin
        tx_push      = io_out_vld & io_out_rdy;
        tx_pop       = tx_vld & tx_rdy;
        tx_wr_nxt    = tx_wr_ptr + (TX_AW + 1)'(tx_push);
        tx_rd_nxt    = tx_rd_ptr + (TX_AW + 1)'(tx_pop);
        tx_empty_nxt = (tx_wr_nxt == tx_rd_nxt);
        tx_full_nxt  = (tx_wr_nxt[TX_AW] != tx_rd_nxt[TX_AW]) &&
                       (tx_wr_nxt[TX_AW-1:0] == tx_rd_nxt[TX_AW-1:0]);
    end

    // io_out_rdy has its own flop so it reads 0 while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr  <= '0;
            tx_rd_ptr  <= '0;
            tx_empty_q <= 1'b1;
            tx_full_q  <= 1'b0;
            io_out_rdy <= 1'b0;
        end else begin
            tx_wr_ptr  <= tx_wr_nxt;
            tx_rd_ptr  <= tx_rd_nxt;
            tx_empty_q <= tx_empty_nxt;
            tx_full_q  <= tx_full_nxt;
            io_out_rdy <= ~tx_full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr[TX_AW-1:0]] <= io_out_data;
    end

    assign tx_vld  = ~tx_empty_q;
    assign tx_data = tx_vld ? tx_mem[tx_rd_ptr[TX_AW-1:0]] : 8'h00;

    // ---------------------------------------------------------------- status
    logic [1:0] err_sticky;

    // A new error in the same cycle as err_clr keeps the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 2'b00;
        end else begin
            err_sticky[0] <= rx_ovf      | (err_sticky[0] & ~err_clr);
            err_sticky[1] <= rx_ferr_evt | (err_sticky[1] & ~err_clr);
        end
    end

    assign io_err = {rx_empty_q, rx_full_q, tx_full_q, err_sticky};

endmodule
